// File: rtl/sru_pkg.sv
// ---------------------------------------------------------------------------
// sru_pkg
// Shared definitions for the SRU spike transmitter:
//   - default frame geometry (NSLOT slots per frame, WW-bit weights)
//   - spike-bit positions inside the 4-bit spike field {E+, E-, I+, I-}
//   - frame sequencer state encoding
// ---------------------------------------------------------------------------
package sru_pkg;

    localparam int NSLOT = 16;
    localparam int WW    = 4;

    // Bit positions inside the spike field, MSB first
    localparam int EP = 3;
    localparam int EN = 2;
    localparam int IP = 1;
    localparam int IN = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLR    = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Next slot index, wrapping from the last slot back to 0
    function automatic logic [3:0] next_slot(input logic [3:0] cur, input logic [3:0] last);
        logic [3:0] nxt;
        if (cur == last) begin
            nxt = 4'd0;
        end else begin
            nxt = cur + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sru_frame_mem.sv
// ---------------------------------------------------------------------------
// sru_frame_mem
// NSLOT x DW register file holding one spike frame.
//   clk, rst_n  : rising-edge clock, async active-low clear of every entry
//   wr_en       : write strobe, wr_addr/wr_data give the entry
//   rd_addr     : combinational read address, rd_data the selected entry
// Addresses at or beyond NSLOT are ignored on write and read back as 0.
// ---------------------------------------------------------------------------
module sru_frame_mem
    import sru_pkg::*;
#(
    parameter int SLOTS = 16,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [3:0]    rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [SLOTS];

    // Storage: cleared on reset, single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en && (int'(wr_addr) < SLOTS)) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read port with out-of-range guard
    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < SLOTS) begin
            rd_data = mem_r[rd_addr];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/sru_spike_tx.sv
// ---------------------------------------------------------------------------
// sru_spike_tx
// Stores a frame of NSLOT {spike, weight} entries and, on start, replays it
// to an SRU one slot per cycle: CLR (accumulator clear), NSLOT STREAM cycles,
// then DONE. All outputs are registered; entry 0 appears two cycles after
// start is sampled.
//   clk, reset           : rising-edge clock, async active-low reset
//   wr_valid/wr_ready    : slot write handshake (accepted only in IDLE)
//   wr_slot/wr_spk/wr_w  : target slot, spike bits {E+,E-,I+,I-}, weight
//   start / busy         : frame request / frame in progress
//   E_plus..I_minus, wi  : spike lines and weight of the current slot
//   sru_clr, slot_idx    : accumulator clear pulse, current slot index
//   frame_done           : one-cycle pulse after the last slot
// ---------------------------------------------------------------------------
module sru_spike_tx #(
    parameter int NSLOT = sru_pkg::NSLOT,
    parameter int WW    = sru_pkg::WW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [3:0]    wr_slot,
    input  logic [3:0]    wr_spk,
    input  logic [WW-1:0] wr_w,
    input  logic          start,
    output logic          busy,
    output logic          E_plus,
    output logic          E_minus,
    output logic          I_plus,
    output logic          I_minus,
    output logic [WW-1:0] wi,
    output logic          sru_clr,
    output logic [3:0]    slot_idx,
    output logic          frame_done
);
    import sru_pkg::*;

    localparam int         DW        = 4 + WW;
    localparam logic [3:0] LAST_SLOT = 4'(NSLOT - 1);

    state_t        state_r;
    logic          wr_ready_r;
    logic          busy_r;
    logic          sru_clr_r;
    logic          frame_done_r;
    logic [3:0]    spk_r;
    logic [WW-1:0] wi_r;
    logic [3:0]    slot_idx_r;

    logic          wr_en_s;
    logic [3:0]    rd_addr_s;
    logic [DW-1:0] rd_data_s;

    assign wr_en_s = wr_valid && wr_ready_r;

    sru_frame_mem #(
        .SLOTS (NSLOT),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (wr_en_s),
        .wr_addr (wr_slot),
        .wr_data ({wr_spk, wr_w}),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Read address runs one slot ahead of the registered outputs
    always_comb begin
        rd_addr_s = 4'd0;
        if (state_r == STREAM) begin
            rd_addr_s = next_slot(slot_idx_r, LAST_SLOT);
        end else begin
            rd_addr_s = 4'd0;
        end
    end

    // Frame sequencer: state plus every registered output, computed from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            wr_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
            sru_clr_r    <= 1'b0;
            frame_done_r <= 1'b0;
            spk_r        <= 4'd0;
            wi_r         <= '0;
            slot_idx_r   <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= CLR;
                        wr_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        sru_clr_r  <= 1'b1;
                    end
                end
                CLR: begin
                    state_r    <= STREAM;
                    sru_clr_r  <= 1'b0;
                    spk_r      <= rd_data_s[WW +: 4];
                    wi_r       <= rd_data_s[WW-1:0];
                    slot_idx_r <= rd_addr_s;
                end
                STREAM: begin
                    if (slot_idx_r == LAST_SLOT) begin
                        // Last slot shown: blank the lines, counter wraps to 0
                        state_r      <= DONE;
                        frame_done_r <= 1'b1;
                        spk_r        <= 4'd0;
                        wi_r         <= '0;
                        slot_idx_r   <= 4'd0;
                    end else begin
                        spk_r      <= rd_data_s[WW +: 4];
                        wi_r       <= rd_data_s[WW-1:0];
                        slot_idx_r <= rd_addr_s;
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    frame_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                    wr_ready_r   <= 1'b1;
                end
                default: begin
                    state_r      <= IDLE;
                    wr_ready_r   <= 1'b1;
                    busy_r       <= 1'b0;
                    sru_clr_r    <= 1'b0;
                    frame_done_r <= 1'b0;
                    spk_r        <= 4'd0;
                    wi_r         <= '0;
                    slot_idx_r   <= 4'd0;
                end
            endcase
        end
    end

    assign wr_ready   = wr_ready_r;
    assign busy       = busy_r;
    assign sru_clr    = sru_clr_r;
    assign frame_done = frame_done_r;
    assign E_plus     = spk_r[EP];
    assign E_minus    = spk_r[EN];
    assign I_plus     = spk_r[IP];
    assign I_minus    = spk_r[IN];
    assign wi         = wi_r;
    assign slot_idx   = slot_idx_r;

endmodule

// File: tb/tb_sru_spike_tx.sv
// ---------------------------------------------------------------------------
// tb_sru_spike_tx
// Self-checking bench: a model frame memory supplies the expected stream,
// pushed to a queue when start is driven and popped as each slot is shown.
// ---------------------------------------------------------------------------
module tb_sru_spike_tx;

    localparam int NS = 16;

    typedef struct {
        logic [3:0] spk;
        logic [3:0] w;
        logic [3:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_slot;
    logic [3:0] wr_spk;
    logic [3:0] wr_w;
    logic       start;
    logic       busy;
    logic       E_plus, E_minus, I_plus, I_minus;
    logic [3:0] wi;
    logic       sru_clr;
    logic [3:0] slot_idx;
    logic       frame_done;

    logic [7:0] mem_m [NS];
    exp_t       exp_q [$];
    int         n_tests = 0;
    int         n_fail  = 0;

    sru_spike_tx #(.NSLOT(NS), .WW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_slot    (wr_slot),
        .wr_spk     (wr_spk),
        .wr_w       (wr_w),
        .start      (start),
        .busy       (busy),
        .E_plus     (E_plus),
        .E_minus    (E_minus),
        .I_plus     (I_plus),
        .I_minus    (I_minus),
        .wi         (wi),
        .sru_clr    (sru_clr),
        .slot_idx   (slot_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input logic [3:0] s, input logic [3:0] spk, input logic [3:0] w);
        check_eq("wr_ready_idle", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_slot  = s;
        wr_spk   = spk;
        wr_w     = w;
        mem_m[s] = {spk, w};
        step();
        wr_valid = 1'b0;
    endtask

    // Caller has raised start (and possibly a write) just after an edge.
    task automatic run_frame(input int restart_at, input int busy_wr_at, input int abort_at);
        exp_t e;
        if (wr_valid) begin
            mem_m[wr_slot] = {wr_spk, wr_w};
        end
        for (int i = 0; i < NS; i++) begin
            e.spk = mem_m[i][7:4];
            e.w   = mem_m[i][3:0];
            e.idx = 4'(i);
            exp_q.push_back(e);
        end
        step();
        start    = 1'b0;
        wr_valid = 1'b0;
        check_eq("clr_pulse", 32'(sru_clr), 32'd1);
        check_eq("clr_busy", 32'(busy), 32'd1);
        check_eq("clr_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("clr_lines", 32'({E_plus, E_minus, I_plus, I_minus, wi, slot_idx}), 32'd0);
        for (int k = 0; k < NS; k++) begin
            start    = (k == restart_at);
            wr_valid = (k == busy_wr_at);
            if (k == busy_wr_at) begin
                wr_slot = 4'd2;
                wr_spk  = 4'hF;
                wr_w    = 4'hF;
            end
            step();
            if (exp_q.size() == 0) begin
                check_eq("q_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("spk", 32'({E_plus, E_minus, I_plus, I_minus}), 32'(e.spk));
                check_eq("wi", 32'(wi), 32'(e.w));
                check_eq("slot_idx", 32'(slot_idx), 32'(e.idx));
                check_eq("stream_ctl", 32'({busy, sru_clr, frame_done, wr_ready}), 32'b1000);
            end
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                check_eq("abort_out",
                         32'({E_plus, E_minus, I_plus, I_minus, wi, slot_idx, busy, sru_clr, frame_done, wr_ready}),
                         32'd1);
                start    = 1'b0;
                wr_valid = 1'b0;
                step();
                check_eq("abort_no_done", 32'({frame_done, busy}), 32'd0);
                reset = 1'b1;
                for (int i = 0; i < NS; i++) begin
                    mem_m[i] = 8'd0;
                end
                exp_q.delete();
                step();
                check_eq("abort_idle", 32'({frame_done, busy, wr_ready}), 32'd1);
                return;
            end
        end
        start    = 1'b0;
        wr_valid = 1'b0;
        step();
        check_eq("done_pulse", 32'(frame_done), 32'd1);
        check_eq("done_busy", 32'(busy), 32'd1);
        check_eq("done_lines", 32'({E_plus, E_minus, I_plus, I_minus, wi, slot_idx}), 32'd0);
        step();
        check_eq("idle_done", 32'(frame_done), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_wr_ready", 32'(wr_ready), 32'd1);
        step();
        check_eq("no_requeue", 32'({busy, sru_clr, frame_done}), 32'd0);
        check_eq("q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_slot  = 4'd0;
        wr_spk   = 4'd0;
        wr_w     = 4'd0;
        start    = 1'b0;
        for (int i = 0; i < NS; i++) begin
            mem_m[i] = 8'd0;
        end
        step();
        step();
        check_eq("rst_out",
                 32'({E_plus, E_minus, I_plus, I_minus, wi, slot_idx, busy, sru_clr, frame_done, wr_ready}),
                 32'd1);
        reset = 1'b1;
        step();

        // Empty frame straight out of reset
        start = 1'b1;
        run_frame(-1, -1, -1);

        // E_plus ramp with weight = slot, then overwrite slot 3
        for (int k = 0; k < NS; k++) begin
            write_slot(4'(k), 4'b1000, 4'(k));
        end
        write_slot(4'd3, 4'b0100, 4'h7);
        write_slot(4'd3, 4'b0010, 4'hC);
        start = 1'b1;
        run_frame(-1, -1, -1);

        // Write slot 5 in the same cycle as start
        wr_valid = 1'b1;
        wr_slot  = 4'd5;
        wr_spk   = 4'b0001;
        wr_w     = 4'hA;
        start    = 1'b1;
        run_frame(-1, -1, -1);

        // Back-to-back frame, same data
        start = 1'b1;
        run_frame(-1, -1, -1);

        // start and a write offered while busy are both ignored
        start = 1'b1;
        run_frame(3, 4, -1);
        start = 1'b1;
        run_frame(-1, -1, -1);

        // Reset at STREAM cycle 7, then an all-zero frame
        start = 1'b1;
        run_frame(-1, -1, 7);
        start = 1'b1;
        run_frame(-1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sru_spike_tx.md
SRU_SPIKE_TX -- requirements
Module: sru_spike_tx

Interface
REQ-001 Parameter NSLOT, default 16, is the number of slots per frame (one slot per cycle of an SRU window).
REQ-002 Parameter WW, default 4, is the weight width.
REQ-003 Port clk, input, 1 bit: single clock; all logic SHALL be rising-edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port wr_valid, input, 1 bit: a slot write is offered.
REQ-006 Port wr_ready, output, 1 bit: a slot write can be accepted.
REQ-007 Port wr_slot, input, 4 bits: target slot index, 0..NSLOT-1.
REQ-008 Port wr_spk, input, 4 bits: spike bits {E_plus, E_minus, I_plus, I_minus}, MSB first.
REQ-009 Port wr_w, input, WW bits: synaptic weight for the slot.
REQ-010 Port start, input, 1 bit: request to transmit the stored frame.
REQ-011 Port busy, output, 1 bit: a frame is in progress.
REQ-012 Ports E_plus, E_minus, I_plus, I_minus, output, 1 bit each: spike lines to the SRU.
REQ-013 Port wi, output, WW bits: weight for the current slot.
REQ-014 Port sru_clr, output, 1 bit: one-cycle clear of the SRU accumulators.
REQ-015 Port slot_idx, output, 4 bits: index of the slot currently driven.
REQ-016 Port frame_done, output, 1 bit: one-cycle pulse after the last slot.

Function
REQ-017 Frame memory SHALL hold NSLOT entries of {spk[3:0], w[WW-1:0]}; a write SHALL occur when wr_valid && wr_ready.
REQ-018 wr_ready SHALL equal 1 in IDLE and 0 in every other state.
REQ-019 FSM states: IDLE, CLR, STREAM, DONE.
REQ-020 IDLE -> CLR when start=1; CLR -> STREAM after 1 cycle; STREAM -> DONE after exactly NSLOT cycles; DONE -> IDLE after 1 cycle.
REQ-021 sru_clr SHALL be 1 only in CLR; frame_done SHALL be 1 only in DONE.
REQ-022 busy SHALL be 1 in CLR, STREAM and DONE.
REQ-023 In STREAM cycle k (k = 0..NSLOT-1), the spike lines, wi and slot_idx SHALL show entry k, with slot_idx = k.
REQ-024 All outputs SHALL be registered; entry 0 SHALL appear exactly 2 cycles after the cycle in which start is sampled.
REQ-025 Outside STREAM, the spike lines and wi SHALL be 0, and slot_idx SHALL hold 0.
REQ-026 A start asserted while busy=1 SHALL be ignored; starts SHALL NOT be queued.
REQ-027 If a write and start occur in the same IDLE cycle, the write SHALL take effect and the streamed frame SHALL include it.
REQ-028 Repeated writes to one slot: the last write wins.
REQ-029 Memory SHALL persist across frames, so a second start retransmits the same data.
REQ-030 The slot counter SHALL wrap from NSLOT-1 to 0 on leaving STREAM.

Reset
REQ-031 While reset=0, the FSM SHALL be in IDLE, and all outputs SHALL be 0 except wr_ready, which SHALL be 1.
REQ-032 While reset=0, all memory entries SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_done pulse.

Structure
REQ-034 A shared package sru_pkg SHALL hold: the FSM state enum, NSLOT, WW, and spike-bit position constants (EP=3, EN=2, IP=1, IN=0).
REQ-035 One sub-module, sru_frame_mem, SHALL be used: an NSLOT x (4+WW) register file with 1 write port, 1 read port and asynchronous clear.

Verification
REQ-036 Scenario: reset, then start with no writes -> sru_clr pulses at cycle +1, 16 cycles of all-zero spikes with wi=0, frame_done at cycle +18.
REQ-037 Scenario: write slot k with spk=4'b1000 and w=k for k = 0..15, then start -> E_plus=1 for 16 consecutive cycles, wi counts 0..15, and slot_idx matches wi.
REQ-038 Scenario: write slot 5 with {0001, 4'hA} in the same cycle as start -> at STREAM cycle 5, I_minus=1 and wi=4'hA.
REQ-039 Scenario: start pulsed again during STREAM -> exactly one frame_done, and busy drops 1 cycle after it; wr_valid offered while busy -> not accepted, and memory is unchanged.
REQ-040 Scenario: reset asserted at STREAM cycle 7 -> all outputs go to 0 immediately, no frame_done, and a subsequent start streams all-zero entries.
REQ-041 Scenario: two back-to-back frames without new writes -> identical spike, wi and slot_idx sequences on both.
